// File: rtl/dsi_word_feeder.sv
// ----------------------------------------------------------------------------
// dsi_word_feeder
//
// Packs a byte stream from the packet builder little-endian into 32-bit words
// with byte strobes, queues them in a small word FIFO and presents the FIFO
// head to the DSI lanes controller over the iface_write_* / iface_data_rqst
// handshake. Flags an underflow when the controller asks for a word in the
// middle of a packet and nothing is buffered.
//
// Parameters:
//   FIFO_DEPTH          word FIFO entries, power of two, 2..16
//
// Ports:
//   clk_sys             system clock, rising edge
//   rst                 asynchronous active-high reset
//   in_data[7:0]        byte from the packet builder
//   in_valid            in_data valid
//   in_last             byte closes the packet
//   in_ready            byte taken on an edge with in_valid && in_ready
//   iface_write_data    FIFO head word, byte k on bits [8k+7:8k]
//   iface_write_strb    FIFO head strobes (f, 7, 3 or 1)
//   iface_write_rqst    a word is available
//   iface_last_word     head word closes the packet
//   iface_data_rqst     controller pops the head when iface_write_rqst is high
//   busy                packet in progress, packer partial, or FIFO non-empty
//   underflow_error     one-cycle pulse after a mid-packet request on empty
//
// Build option:
//   DSI_FEEDER_UNDERFLOW_CNT_EN  adds underflow_count[15:0], a saturating
//                                count of underflow_error pulses.
// ----------------------------------------------------------------------------
module dsi_word_feeder #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        rst,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    input  logic        in_last,
    output logic        in_ready,
    output logic [31:0] iface_write_data,
    output logic [3:0]  iface_write_strb,
    output logic        iface_write_rqst,
    output logic        iface_last_word,
    input  logic        iface_data_rqst,
    output logic        busy,
    output logic        underflow_error
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    ,
    output logic [15:0] underflow_count
`endif
);

    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_COUNT = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } stateT;

    logic [1:0]    r_byteIdx;
    logic [23:0]   r_hold;
    logic [36:0]   r_mem [FIFO_DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [AW:0]   r_count;
    stateT         r_state;
    stateT         w_nextState;
    logic          r_underflow;
    logic          w_underflowNext;

    logic          w_empty;
    logic          w_full;
    logic          w_accept;
    logic          w_complete;
    logic          w_push;
    logic          w_pop;
    logic [31:0]   w_laneData;
    logic [31:0]   w_wordData;
    logic [3:0]    w_wordStrb;
    logic [36:0]   w_head;

    // Handshake qualifiers: a word is pushed when the byte that closes it is
    // accepted, and popped when the controller asks while a word is present.
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == FULL_COUNT);
    assign w_accept   = in_valid && !w_full;
    assign w_complete = (r_byteIdx == 2'd3) || in_last;
    assign w_push     = w_accept && w_complete;
    assign w_pop      = iface_data_rqst && !w_empty;

    // The incoming byte moved into its lane. Lanes above the current index
    // stay zero in the holding register, so OR-ing gives the finished word
    // with zeroed upper lanes for short tails.
    assign w_laneData = {24'h000000, in_data} << {r_byteIdx, 3'b000};
    assign w_wordData = {8'h00, r_hold} | w_laneData;

    // Strobe covers lanes 0..idx of the word being closed.
    always_comb begin
        w_wordStrb = 4'h1;
        case (r_byteIdx)
            2'd0: w_wordStrb = 4'h1;
            2'd1: w_wordStrb = 4'h3;
            2'd2: w_wordStrb = 4'h7;
            2'd3: w_wordStrb = 4'hf;
            default: w_wordStrb = 4'h1;
        endcase
    end

    // Packer: collect bytes into the holding register; closing a word clears
    // it so the next packet starts from lane 0.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_byteIdx <= 2'd0;
            r_hold    <= 24'h000000;
        end else if (w_accept) begin
            if (w_complete) begin
                r_byteIdx <= 2'd0;
                r_hold    <= 24'h000000;
            end else begin
                r_byteIdx <= r_byteIdx + 2'd1;
                r_hold    <= r_hold | w_laneData[23:0];
            end
        end
    end

    // Word storage; contents are only visible through the empty-gated head,
    // so it needs no reset.
    always_ff @(posedge clk_sys) begin
        if (w_push) begin
            r_mem[r_wrPtr] <= {in_last, w_wordStrb, w_wordData};
        end
    end

    // FIFO pointers and occupancy. Simultaneous push and pop leave the count
    // unchanged, which keeps in_ready high through full-rate streaming.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (AW + 1)'(1);
                2'b01:   r_count <= r_count - (AW + 1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_head           = w_empty ? 37'd0 : r_mem[r_rdPtr];
    assign iface_write_data = w_head[31:0];
    assign iface_write_strb = w_head[35:32];
    assign iface_last_word  = w_head[36];
    assign iface_write_rqst = !w_empty;
    assign in_ready         = !w_full;

    // Packet FSM state register.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Every pop decides the state: a closing word ends (or never opens) the
    // packet, any other word means more words of this packet are due.
    always_comb begin
        w_nextState = r_state;
        if (w_pop) begin
            w_nextState = w_head[36] ? IDLE : ACTIVE;
        end
    end

    // A request on an empty FIFO only counts as an underflow while a packet
    // is open; idle requests are ignored.
    always_comb begin
        w_underflowNext = 1'b0;
        if ((r_state == ACTIVE) && iface_data_rqst && w_empty) begin
            w_underflowNext = 1'b1;
        end
    end

    // Underflow pulse lands in the cycle after the offending edge.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_underflow <= 1'b0;
        end else begin
            r_underflow <= w_underflowNext;
        end
    end

    assign underflow_error = r_underflow;
    assign busy = (r_state == ACTIVE) || (r_byteIdx != 2'd0) || !w_empty;

`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] r_underflowCount;

    // Saturating count of underflow pulses; cleared only by reset.
    always_ff @(posedge clk_sys or posedge rst) begin
        if (rst) begin
            r_underflowCount <= 16'h0000;
        end else if (r_underflow && (r_underflowCount != 16'hffff)) begin
            r_underflowCount <= r_underflowCount + 16'h0001;
        end
    end

    assign underflow_count = r_underflowCount;
`endif

endmodule

// File: tb/tb_dsi_word_feeder.sv
// ----------------------------------------------------------------------------
// tb_dsi_word_feeder
//
// Self-checking bench for dsi_word_feeder: a table of hand-derived vectors for
// the basic packing cases, hand-written sequences for FIFO-full, underflow and
// mid-packet reset, then randomized traffic against a queue-based model.
// ----------------------------------------------------------------------------
module tb_dsi_word_feeder;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        rst;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] iface_write_data;
    logic [3:0]  iface_write_strb;
    logic        iface_write_rqst;
    logic        iface_last_word;
    logic        iface_data_rqst;
    logic        busy;
    logic        underflow_error;
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
    logic [15:0] underflow_count;
`endif

    int testsRun    = 0;
    int testsFailed = 0;

    // Observable outputs bundled for one-shot comparison.
    typedef struct packed {
        logic        ready;
        logic        rqst;
        logic [31:0] data;
        logic [3:0]  strb;
        logic        last;
        logic        busyV;
        logic        uf;
    } outT;

    typedef struct {
        logic       v;
        logic [7:0] d;
        logic       l;
        logic       r;
        outT        exp;
    } vecT;

    // Reference model: complete words waiting for the controller, bytes of
    // the word being assembled, whether a packet is open, the pending
    // underflow pulse and the pulse counter.
    logic [36:0] mWords [$];
    logic [7:0]  mBytes [$];
    bit          mActive;
    bit          mUnder;
    int          mCount;

    dsi_word_feeder #(.FIFO_DEPTH(DEPTH)) dut (
        .clk_sys          (clk_sys),
        .rst              (rst),
        .in_data          (in_data),
        .in_valid         (in_valid),
        .in_last          (in_last),
        .in_ready         (in_ready),
        .iface_write_data (iface_write_data),
        .iface_write_strb (iface_write_strb),
        .iface_write_rqst (iface_write_rqst),
        .iface_last_word  (iface_last_word),
        .iface_data_rqst  (iface_data_rqst),
        .busy             (busy),
        .underflow_error  (underflow_error)
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        ,
        .underflow_count  (underflow_count)
`endif
    );

    always #5 clk_sys = ~clk_sys;

    // Hard stop in case something upstream never returns.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic outT mkExp(input logic ready, input logic rqst,
                                  input logic [31:0] data, input logic [3:0] strb,
                                  input logic last, input logic busyV, input logic uf);
        outT o;
        o.ready = ready;
        o.rqst  = rqst;
        o.data  = data;
        o.strb  = strb;
        o.last  = last;
        o.busyV = busyV;
        o.uf    = uf;
        return o;
    endfunction

    function automatic outT sampleDut();
        return mkExp(in_ready, iface_write_rqst, iface_write_data, iface_write_strb,
                     iface_last_word, busy, underflow_error);
    endfunction

    function automatic outT modelExpected();
        logic [36:0] head;
        head = (mWords.size() > 0) ? mWords[0] : 37'd0;
        return mkExp(mWords.size() < DEPTH, mWords.size() > 0, head[31:0], head[35:32],
                     head[36], mActive || (mBytes.size() > 0) || (mWords.size() > 0), mUnder);
    endfunction

    function automatic void modelClear();
        mWords.delete();
        mBytes.delete();
        mActive = 1'b0;
        mUnder  = 1'b0;
        mCount  = 0;
    endfunction

    task automatic checkOutput(input string name, input outT act, input outT exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual rdy=%b rqst=%b data=%h strb=%h last=%b busy=%b uf=%b, required rdy=%b rqst=%b data=%h strb=%h last=%b busy=%b uf=%b",
                     name, act.ready, act.rqst, act.data, act.strb, act.last, act.busyV, act.uf,
                     exp.ready, exp.rqst, exp.data, exp.strb, exp.last, exp.busyV, exp.uf);
        end
    endtask

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s: actual %h, required %h", name, act, exp);
        end
    endtask

    // One clock of stimulus. The model is advanced from the pre-edge state
    // following the block's rules, then all outputs are compared 1 time unit
    // after the edge.
    task automatic applyStimulus(input logic v, input logic [7:0] d, input logic l,
                                 input logic r, output bit accepted);
        bit          popNow;
        bit          underNow;
        logic [36:0] w;
        logic [31:0] wd;
        in_valid        = v;
        in_data         = d;
        in_last         = l;
        iface_data_rqst = r;
        accepted = v && (mWords.size() < DEPTH);
        popNow   = r && (mWords.size() > 0);
        underNow = mActive && r && (mWords.size() == 0);
        if (mUnder && mCount < 65535) mCount++;
        if (popNow) begin
            w = mWords.pop_front();
            mActive = !w[36];
        end
        if (accepted) begin
            mBytes.push_back(d);
            if (l || mBytes.size() == 4) begin
                wd = 32'h0;
                for (int k = 0; k < mBytes.size(); k++) wd |= 32'(mBytes[k]) << (8 * k);
                mWords.push_back({l, 4'((1 << mBytes.size()) - 1), wd});
                mBytes.delete();
            end
        end
        mUnder = underNow;
        @(posedge clk_sys);
        #1;
        checkOutput("cycle", sampleDut(), modelExpected());
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        checkValue("underflowCount", 32'(underflow_count), 32'(mCount));
`endif
    endtask

    task automatic applyReset();
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_data         = 8'h00;
        in_last         = 1'b0;
        iface_data_rqst = 1'b0;
        repeat (2) @(posedge clk_sys);
        @(negedge clk_sys);
        rst = 1'b0;
        @(posedge clk_sys);
        #1;
        modelClear();
    endtask

    vecT         vec [20];
    bit          acc;
    logic [7:0]  fb [20];
    logic [31:0] expw [5];
    logic [31:0] got [$];
    int          bi;
    int          cyc;
    int          pulses;
    logic        r;
    logic        uv [12];
    logic [7:0]  ud [12];
    int          bias;

    initial begin
        // Packing vectors: 4-byte packet, 5-byte packet, then 1/2/3-byte tails.
        vec[0]  = '{1'b1, 8'h11, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[1]  = '{1'b1, 8'h22, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[2]  = '{1'b1, 8'h33, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[3]  = '{1'b1, 8'h44, 1'b1, 1'b1, mkExp(1, 1, 32'h44332211, 4'hf, 1, 1, 0)};
        vec[4]  = '{1'b0, 8'h00, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0)};
        vec[5]  = '{1'b0, 8'h00, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0)};
        vec[6]  = '{1'b1, 8'h01, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[7]  = '{1'b1, 8'h02, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[8]  = '{1'b1, 8'h03, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[9]  = '{1'b1, 8'h04, 1'b0, 1'b1, mkExp(1, 1, 32'h04030201, 4'hf, 0, 1, 0)};
        vec[10] = '{1'b1, 8'h05, 1'b1, 1'b1, mkExp(1, 1, 32'h00000005, 4'h1, 1, 1, 0)};
        vec[11] = '{1'b0, 8'h00, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0)};
        vec[12] = '{1'b0, 8'h00, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0)};
        vec[13] = '{1'b1, 8'hA1, 1'b1, 1'b1, mkExp(1, 1, 32'h000000A1, 4'h1, 1, 1, 0)};
        vec[14] = '{1'b1, 8'hB1, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[15] = '{1'b1, 8'hB2, 1'b1, 1'b1, mkExp(1, 1, 32'h0000B2B1, 4'h3, 1, 1, 0)};
        vec[16] = '{1'b1, 8'hC1, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[17] = '{1'b1, 8'hC2, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 1, 0)};
        vec[18] = '{1'b1, 8'hC3, 1'b1, 1'b1, mkExp(1, 1, 32'h00C3C2C1, 4'h7, 1, 1, 0)};
        vec[19] = '{1'b0, 8'h00, 1'b0, 1'b1, mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0)};

        // Reset state before any clock edge.
        rst             = 1'b1;
        in_valid        = 1'b0;
        in_data         = 8'h00;
        in_last         = 1'b0;
        iface_data_rqst = 1'b0;
        #3;
        checkOutput("resetState", sampleDut(), mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0));
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        checkValue("resetCount", 32'(underflow_count), 32'h0);
`endif
        applyReset();

        for (int i = 0; i < 20; i++) begin
            in_valid        = vec[i].v;
            in_data         = vec[i].d;
            in_last         = vec[i].l;
            iface_data_rqst = vec[i].r;
            @(posedge clk_sys);
            #1;
            checkOutput($sformatf("vec%0d", i), sampleDut(), vec[i].exp);
        end

        // FIFO full: 20 bytes with the controller stalled, then drain.
        applyReset();
        for (int i = 0; i < 20; i++) fb[i] = 8'(8'h30 + i);
        expw[0] = 32'h33323130;
        expw[1] = 32'h37363534;
        expw[2] = 32'h3b3a3938;
        expw[3] = 32'h3f3e3d3c;
        expw[4] = 32'h43424140;
        got.delete();
        bi  = 0;
        cyc = 0;
        while (bi < 20 && cyc < 200) begin
            r = (cyc >= 20);
            if (r && iface_write_rqst) got.push_back(iface_write_data);
            applyStimulus(1'b1, fb[bi], bi == 19, r, acc);
            if (acc) begin
                bi++;
                if (bi == 16) checkValue("fullInReady", 32'(in_ready), 32'h0);
            end
            cyc++;
        end
        if (bi < 20) checkValue("fullStreamTimeout", 32'(bi), 32'd20);
        for (int i = 0; i < 10; i++) begin
            if (iface_write_rqst) got.push_back(iface_write_data);
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
        end
        checkValue("drainCount", 32'(got.size()), 32'd5);
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            checkValue($sformatf("drainWord%0d", k), got[k], expw[k]);
        end

        // Underflow: 8-byte packet with a 4-cycle gap after the first word.
        applyReset();
        uv = '{1, 1, 1, 1, 0, 0, 0, 0, 1, 1, 1, 1};
        ud = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00,
               8'h05, 8'h06, 8'h07, 8'h08};
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            applyStimulus(uv[i], ud[i], i == 11, 1'b1, acc);
            if (underflow_error) pulses++;
        end
        checkValue("uflowWord2Data", iface_write_data, 32'h08070605);
        checkValue("uflowWord2Strb", 32'(iface_write_strb), 32'hf);
        checkValue("uflowWord2Last", 32'(iface_last_word), 32'h1);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, acc);
            if (underflow_error) pulses++;
        end
        checkValue("uflowPulses", 32'(pulses), 32'd7);
`ifdef DSI_FEEDER_UNDERFLOW_CNT_EN
        checkValue("uflowCountTotal", 32'(underflow_count), 32'd7);
`endif

        // Reset with two words buffered and a half-built third word.
        applyReset();
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 8'(8'h50 + i), 1'b0, 1'b0, acc);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midPacketReset", sampleDut(), mkExp(1, 0, 32'h0, 4'h0, 0, 0, 0));
        modelClear();
        @(negedge clk_sys);
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'hD1, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'hD2, 1'b0, 1'b0, acc);
        applyStimulus(1'b1, 8'hD3, 1'b1, 1'b0, acc);
        checkValue("postResetWord", iface_write_data, 32'h00D3D2D1);
        checkValue("postResetStrb", 32'(iface_write_strb), 32'h7);

        // Randomized traffic with varying controller pull rate.
        applyReset();
        for (int i = 0; i < 800; i++) begin
            bias = 2 + ((i / 100) % 8);
            applyStimulus($urandom_range(0, 9) < 7, 8'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 9) < bias, acc);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
